// File: rtl/ibex_mem_arbiter_if.sv
// Bus bundle between the ibex instruction/data ports, the arbiter and ram_1p.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system: it drives core requests and returns RAM responses.
interface ibex_mem_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// Two-master (instruction fetch, load/store) to one single-port RAM arbiter.
// Grants are combinational. The one-cycle RAM response, or a locally generated
// out-of-window error, is routed back to the previous cycle's winner. A
// streak counter caps consecutive fetch grants while data is waiting.
module ibex_mem_arbiter #(
    parameter logic [31:0] MemStart       = 32'h0000_0000,
    parameter int unsigned MemSize        = 65536,
    parameter int unsigned MaxInstrStreak = 4
) (
    input logic               clk_i,
    input logic               rst_ni,
    ibex_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_e;

    localparam logic [31:0] AddrMask  = ~(32'(MemSize) - 32'd1);
    localparam logic [3:0]  StreakMax = 4'(MaxInstrStreak);

    owner_e      owner_q, owner_d;
    logic        err_q, err_d;
    logic [3:0]  streak_q, streak_d;
    logic        instr_win, data_win, in_window;
    logic [31:0] win_addr;

    // Pick this cycle's winner, drive grants and the RAM strobe, compute next state.
    always_comb begin
        instr_win       = 1'b0;
        data_win        = 1'b0;
        win_addr        = 32'h0;
        in_window       = 1'b0;
        owner_d         = OWNER_NONE;
        err_d           = 1'b0;
        streak_d        = 4'h0;
        bus.instr_gnt_o = 1'b0;
        bus.data_gnt_o  = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 32'h0;

        if (rst_ni) begin
            if (bus.instr_req_i && (!bus.data_req_i || streak_q != StreakMax)) begin
                instr_win = 1'b1;
            end else if (bus.data_req_i) begin
                data_win = 1'b1;
            end
        end

        if (instr_win) begin
            win_addr = bus.instr_addr_i;
        end else if (data_win) begin
            win_addr = bus.data_addr_i;
        end
        in_window = ((win_addr & AddrMask) == MemStart);

        if (instr_win) begin
            bus.instr_gnt_o = 1'b1;
            owner_d         = OWNER_INSTR;
            err_d           = !in_window;
            if (in_window) begin
                bus.mem_req_o  = 1'b1;
                bus.mem_be_o   = 4'hF;
                bus.mem_addr_o = bus.instr_addr_i;
            end
        end else if (data_win) begin
            bus.data_gnt_o = 1'b1;
            owner_d        = OWNER_DATA;
            err_d          = !in_window;
            if (in_window) begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end
        end

        if (instr_win && bus.data_req_i) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 4'h1;
        end
    end

    // Remember who owns the in-flight response and whether it is an error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= OWNER_NONE;
            err_q    <= 1'b0;
            streak_q <= 4'h0;
        end else begin
            owner_q  <= owner_d;
            err_q    <= err_d;
            streak_q <= streak_d;
        end
    end

    // Steer the RAM response, or the recorded error, to the previous winner.
    always_comb begin
        bus.instr_rvalid_o = (owner_q == OWNER_INSTR);
        bus.data_rvalid_o  = (owner_q == OWNER_DATA);
        bus.instr_err_o    = bus.instr_rvalid_o && err_q;
        bus.data_err_o     = bus.data_rvalid_o && err_q;
        bus.instr_rdata_o  = (bus.instr_rvalid_o && !err_q) ? bus.mem_rdata_i : 32'h0;
        bus.data_rdata_o   = (bus.data_rvalid_o && !err_q) ? bus.mem_rdata_i : 32'h0;
    end

    mem_rvalid_check: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mem_rvalid_i == ((owner_q != OWNER_NONE) && !err_q));
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomized scoreboard bench for ibex_mem_arbiter with a behavioural RAM.
module tb_ibex_mem_arbiter;
    localparam int unsigned MaxStreak = 4;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int unsigned cyc;
        logic        is_data;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    ibex_mem_arbiter_if bus();

    ibex_mem_arbiter #(
        .MemStart       (32'h0000_0000),
        .MemSize        (65536),
        .MaxInstrStreak (MaxStreak)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    req_t        instr_q[$];
    req_t        data_q[$];
    rsp_t        sb_q[$];
    logic [31:0] ram     [16384];
    logic [31:0] ref_mem [16384];
    int unsigned cycle_cnt = 0;
    int          n_checks  = 0;
    int          n_fails   = 0;
    int          model_streak = 0;
    string       grant_log = "";

    rsp_t        mon_rsp;
    logic        exp_irv, exp_ierr, exp_drv, exp_derr;
    logic [31:0] exp_ird, exp_drd;

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Cycle number used to tag when each response is due.
    always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

    // Behavioural single-port RAM: one-cycle read latency, old data on write.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.mem_rvalid_i <= 1'b0;
        end else begin
            bus.mem_rvalid_i <= bus.mem_req_o;
            if (bus.mem_req_o) begin
                bus.mem_rdata_i <= ram[bus.mem_addr_o[15:2]];
                if (bus.mem_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.mem_be_o[b]) begin
                            ram[bus.mem_addr_o[15:2]][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    task automatic compare_value(input string name, input logic [31:0] actual,
                                 input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    function automatic req_t make_instr_req(input logic [31:0] addr);
        req_t r;
        r.we    = 1'b0;
        r.be    = 4'hF;
        r.addr  = addr;
        r.wdata = 32'h0;
        return r;
    endfunction

    function automatic req_t make_data_req(input logic we, input logic [3:0] be,
                                           input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we    = we;
        r.be    = be;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(7) == 0) begin
            a = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
        end else begin
            a = {16'h0, 14'($urandom), 2'b00};
        end
        return a;
    endfunction

    // Present the head of each master's request queue; held until granted.
    task automatic applyStimulus();
        bus.instr_req_i  = (instr_q.size() > 0);
        bus.instr_addr_i = (instr_q.size() > 0) ? instr_q[0].addr : 32'h0;
        bus.data_req_i   = (data_q.size() > 0);
        bus.data_we_i    = (data_q.size() > 0) ? data_q[0].we : 1'b0;
        bus.data_be_i    = (data_q.size() > 0) ? data_q[0].be : 4'h0;
        bus.data_addr_i  = (data_q.size() > 0) ? data_q[0].addr : 32'h0;
        bus.data_wdata_i = (data_q.size() > 0) ? data_q[0].wdata : 32'h0;
    endtask

    // Decide the winner from the arbitration rules, check grant and RAM
    // strobe, and queue the response that is due next cycle.
    task automatic checkOutput();
        logic        iw, dw, win_i, win_d, inwin;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
        req_t        r;
        rsp_t        rsp;

        iw    = rst_ni && (instr_q.size() > 0);
        dw    = rst_ni && (data_q.size() > 0);
        win_i = iw && (!dw || model_streak < MaxStreak);
        win_d = dw && !win_i;
        e_req = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
        inwin = 1'b0;

        if (bus.instr_gnt_o) grant_log = {grant_log, "I"};
        if (bus.data_gnt_o)  grant_log = {grant_log, "D"};
        compare_value("instr_gnt", bus.instr_gnt_o, win_i);
        compare_value("data_gnt", bus.data_gnt_o, win_d);

        if (win_i || win_d) begin
            r = win_i ? instr_q.pop_front() : data_q.pop_front();
            inwin       = (r.addr < 32'h0001_0000);
            rsp.cyc     = cycle_cnt + 1;
            rsp.is_data = win_d;
            rsp.err     = !inwin;
            rsp.rdata   = inwin ? ref_mem[r.addr[15:2]] : 32'h0;
            sb_q.push_back(rsp);
            if (inwin) begin
                e_req = 1'b1; e_we = r.we; e_be = r.be; e_addr = r.addr; e_wdata = r.wdata;
                if (r.we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r.be[b]) ref_mem[r.addr[15:2]][8*b +: 8] = r.wdata[8*b +: 8];
                    end
                end
            end
        end

        if (win_i && dw) begin
            model_streak = (model_streak + 1 > MaxStreak) ? MaxStreak : model_streak + 1;
        end else begin
            model_streak = 0;
        end

        compare_value("mem_req", bus.mem_req_o, e_req);
        if (e_req || !(win_i || win_d)) begin
            compare_value("mem_we", bus.mem_we_o, e_we);
            compare_value("mem_be", bus.mem_be_o, e_be);
            compare_value("mem_addr", bus.mem_addr_o, e_addr);
            compare_value("mem_wdata", bus.mem_wdata_o, e_wdata);
        end
    endtask

    task automatic run_cycle();
        applyStimulus();
        @(negedge clk_i);
        checkOutput();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((instr_q.size() > 0 || data_q.size() > 0) && n < 200) begin
            run_cycle();
            n++;
        end
        compare_value("drain_pending", instr_q.size() + data_q.size(), 0);
        run_cycle();
    endtask

    // Response monitor: every cycle, pop the response due now (if any) and
    // compare both ports against it; otherwise both ports must be idle.
    always @(negedge clk_i) begin
        exp_irv = 1'b0; exp_ierr = 1'b0; exp_ird = 32'h0;
        exp_drv = 1'b0; exp_derr = 1'b0; exp_drd = 32'h0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cycle_cnt) begin
            mon_rsp = sb_q.pop_front();
            if (mon_rsp.is_data) begin
                exp_drv = 1'b1; exp_derr = mon_rsp.err; exp_drd = mon_rsp.rdata;
            end else begin
                exp_irv = 1'b1; exp_ierr = mon_rsp.err; exp_ird = mon_rsp.rdata;
            end
        end
        compare_value("instr_rvalid", bus.instr_rvalid_o, exp_irv);
        compare_value("instr_err", bus.instr_err_o, exp_ierr);
        compare_value("instr_rdata", bus.instr_rdata_o, exp_ird);
        compare_value("data_rvalid", bus.data_rvalid_o, exp_drv);
        compare_value("data_err", bus.data_err_o, exp_derr);
        compare_value("data_rdata", bus.data_rdata_o, exp_drd);
    end

    // Directed scenarios followed by a randomized stretch.
    initial begin
        logic [31:0] v;
        for (int i = 0; i < 16384; i++) begin
            v = (i * 32'h9E37_79B9) ^ 32'hA5A5_0000;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[128]     = 32'hFFFF_FFFF;
        ref_mem[128] = 32'hFFFF_FFFF;

        // Request pending across reset release: ignored in reset, granted right after.
        instr_q.push_back(make_instr_req(32'h0000_0080));
        repeat (3) run_cycle();
        rst_ni = 1'b1;
        drain();

        // Full store followed by a load of the same word.
        data_q.push_back(make_data_req(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF));
        data_q.push_back(make_data_req(1'b0, 4'hF, 32'h0000_0100, 32'h0));
        drain();

        // Load just past the end of the 64 kB window.
        data_q.push_back(make_data_req(1'b0, 4'hF, 32'h0001_0000, 32'h0));
        drain();

        // Half-word store into an all-ones word, then read it back.
        data_q.push_back(make_data_req(1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678));
        data_q.push_back(make_data_req(1'b0, 4'hF, 32'h0000_0200, 32'h0));
        drain();

        // Both masters busy: fetch streak is capped and data slips in.
        grant_log = "";
        for (int k = 0; k < 12; k++) instr_q.push_back(make_instr_req(32'(k * 4)));
        for (int k = 0; k < 4; k++) data_q.push_back(make_data_req(1'b0, 4'hF, 32'(16'h400 + k * 4), 32'h0));
        drain();
        n_checks++;
        if (grant_log.substr(0, 9) != "IIIIDIIIID") begin
            n_fails++;
            $display("[TB] FAIL grant_pattern: got %s, expected IIIIDIIIID...", grant_log);
        end

        // Reset on the edge after a fetch grant: the response is dropped.
        instr_q.push_back(make_instr_req(32'h0000_0040));
        run_cycle();
        rst_ni = 1'b0;
        sb_q.delete();
        model_streak = 0;
        instr_q.push_back(make_instr_req(32'h0000_0044));
        data_q.push_back(make_data_req(1'b0, 4'hF, 32'h0000_0500, 32'h0));
        run_cycle();
        rst_ni = 1'b1;
        grant_log = "";
        for (int k = 0; k < 9; k++) instr_q.push_back(make_instr_req(32'(16'h800 + k * 4)));
        for (int k = 0; k < 2; k++) data_q.push_back(make_data_req(1'b0, 4'hF, 32'(16'h600 + k * 4), 32'h0));
        drain();
        n_checks++;
        if (grant_log.substr(0, 9) != "IIIIDIIIID") begin
            n_fails++;
            $display("[TB] FAIL post_reset_pattern: got %s, expected IIIIDIIIID...", grant_log);
        end

        // Random traffic from both masters.
        for (int c = 0; c < 1500; c++) begin
            if (instr_q.size() == 0 && $urandom_range(3) != 0) begin
                instr_q.push_back(make_instr_req(rand_addr()));
            end
            if (data_q.size() == 0 && $urandom_range(2) == 0) begin
                data_q.push_back(make_data_req(1'($urandom), 4'($urandom), rand_addr(), $urandom));
            end
            run_cycle();
        end
        drain();
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
